// File: rtl/scc_channel_regfile_pkg.sv
// Shared constants and address decoding for the SCC channel register file.
// The sequencer and the register file both import this package.
package scc_regfile_pkg;

   localparam logic [5:0] FREQ_BASE = 6'h00;
   localparam logic [5:0] VOL_BASE  = 6'h20;
   localparam logic [5:0] EN_BASE   = 6'h30;
   localparam logic [5:0] MODE_ADDR = 6'h3F;

   localparam int MODE_ATOMIC = 0;
   localparam int MODE_FRESET = 5;

   localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_FREQ_LO,
      REG_FREQ_HI,
      REG_VOL,
      REG_EN_LO,
      REG_EN_HI,
      REG_MODE
   } reg_kind_e;

   typedef struct packed {
      reg_kind_e  kind;
      logic [3:0] chan;
   } reg_sel_t;

   // Channel-indexed registers beyond the configured channel count decode as REG_NONE.
   function automatic reg_sel_t decode_addr(input logic [5:0] addr, input int channels);
      reg_sel_t sel;
      sel.kind = REG_NONE;
      sel.chan = 4'd0;
      if (addr[5] == 1'b0) begin
         sel.chan = addr[4:1];
         sel.kind = addr[0] ? REG_FREQ_HI : REG_FREQ_LO;
         if (int'(sel.chan) >= channels) sel.kind = REG_NONE;
      end else if (addr[5:4] == VOL_BASE[5:4]) begin
         sel.chan = addr[3:0];
         sel.kind = REG_VOL;
         if (int'(sel.chan) >= channels) sel.kind = REG_NONE;
      end else if (addr == EN_BASE) begin
         sel.kind = REG_EN_LO;
      end else if (addr == EN_BASE + 6'd1) begin
         sel.kind = REG_EN_HI;
      end else if (addr == MODE_ADDR) begin
         sel.kind = REG_MODE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/scc_channel_regfile_if.sv
// CPU-side byte access bus of the SCC channel register file.
interface scc_channel_regfile_if;

   logic       wrreq;
   logic       rdreq;
   logic [5:0] address;
   logic [7:0] wrdata;
   logic [7:0] rddata;
   logic       rddata_en;

   modport master (
      output wrreq,
      output rdreq,
      output address,
      output wrdata,
      input  rddata,
      input  rddata_en
   );

   modport slave (
      input  wrreq,
      input  rdreq,
      input  address,
      input  wrdata,
      output rddata,
      output rddata_en
   );

endinterface

// File: rtl/scc_channel_regfile_sequencer.sv
// Wrapping channel counter that walks the wave engine through every channel.
// next_index lets the register file preload the slot outputs in step with ch_index.
module scc_channel_sequencer #(
   parameter  int CHANNELS = 5,
   localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seq_en,
   output logic [IDX_W-1:0] ch_index,
   output logic [IDX_W-1:0] next_index,
   output logic             frame_start
);

   always_comb begin
      next_index = ch_index;
      if (seq_en) begin
         if (ch_index == IDX_W'(CHANNELS - 1)) begin
            next_index = '0;
         end else begin
            next_index = ch_index + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_index    <= '0;
         frame_start <= 1'b1;
      end else begin
         ch_index    <= next_index;
         frame_start <= (next_index == '0);
      end
   end

endmodule

// File: rtl/scc_channel_regfile.sv
// Parametrised SCC control-register set with atomic frequency commit and
// phase-reset requests, presenting one channel per cycle to the wave engine.
module scc_channel_regfile #(
   parameter  int CHANNELS = 5,
   parameter  int FREQ_W   = 12,
   parameter  int VOL_W    = 4,
   localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   scc_channel_regfile_if.slave  bus,
   input  logic                  seq_en,
   output logic [IDX_W-1:0]      ch_index,
   output logic [FREQ_W-1:0]     ch_frequency,
   output logic [VOL_W-1:0]      ch_volume,
   output logic                  ch_enable,
   output logic                  ch_phase_reset,
   output logic                  frame_start
);

   import scc_regfile_pkg::*;

   logic [FREQ_W-1:0]   freq_q   [CHANNELS];
   logic [7:0]          shadow_q [CHANNELS];
   logic [VOL_W-1:0]    vol_q    [CHANNELS];
   logic [CHANNELS-1:0] pending_q;
   logic [CHANNELS-1:0] phase_q;
   logic [CHANNELS-1:0] enable_q;
   logic                atomic_q;
   logic                freset_q;

   logic [FREQ_W-1:0]   freq_d   [CHANNELS];
   logic [CHANNELS-1:0] freq_we;
   logic [CHANNELS-1:0] shadow_we;
   logic [CHANNELS-1:0] phase_set;

   logic [IDX_W-1:0]    next_index;
   reg_sel_t            sel;
   logic                rd_accept;
   logic [7:0]          rd_value;
   logic [7:0]          rd_lo;
   logic [7:0]          rd_hi;
   logic [7:0]          rd_vol;
   logic [15:0]         en_ext;

   logic [FREQ_W-1:0]   slot_freq;
   logic [VOL_W-1:0]    slot_vol;
   logic                slot_en;
   logic                slot_phase;

   scc_channel_sequencer #(
      .CHANNELS (CHANNELS)
   ) u_sequencer (
      .clk         (clk),
      .reset       (reset),
      .seq_en      (seq_en),
      .ch_index    (ch_index),
      .next_index  (next_index),
      .frame_start (frame_start)
   );

   assign sel       = decode_addr(bus.address, CHANNELS);
   assign rd_accept = bus.rdreq && !bus.wrreq;

   // In atomic mode a low byte only parks in the shadow; the high byte commits both halves.
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         freq_d[k]    = freq_q[k];
         freq_we[k]   = 1'b0;
         shadow_we[k] = 1'b0;
         if (bus.wrreq && int'(sel.chan) == k) begin
            if (sel.kind == REG_FREQ_LO) begin
               if (atomic_q) begin
                  shadow_we[k] = 1'b1;
               end else begin
                  freq_d[k][7:0] = bus.wrdata;
                  freq_we[k]     = 1'b1;
               end
            end else if (sel.kind == REG_FREQ_HI) begin
               freq_d[k][FREQ_W-1:8] = bus.wrdata[FREQ_W-9:0];
               if (atomic_q && pending_q[k]) freq_d[k][7:0] = shadow_q[k];
               freq_we[k] = 1'b1;
            end
         end
         phase_set[k] = freq_we[k] && freset_q && (freq_d[k] != freq_q[k]);
      end
   end

   // A phase-reset request outlives the slot it coincides with, so set takes priority over clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            freq_q[k]   <= '0;
            shadow_q[k] <= '0;
            vol_q[k]    <= '0;
         end
         pending_q <= '0;
         phase_q   <= '0;
         enable_q  <= '0;
         atomic_q  <= 1'b0;
         freset_q  <= 1'b0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            freq_q[k] <= freq_d[k];
            if (shadow_we[k]) begin
               shadow_q[k]  <= bus.wrdata;
               pending_q[k] <= 1'b1;
            end else if (freq_we[k] && atomic_q) begin
               pending_q[k] <= 1'b0;
            end
            if (bus.wrreq && sel.kind == REG_VOL && int'(sel.chan) == k) begin
               vol_q[k] <= bus.wrdata[VOL_W-1:0];
            end
            if (bus.wrreq && ((sel.kind == REG_EN_LO && k < 8) || (sel.kind == REG_EN_HI && k >= 8))) begin
               enable_q[k] <= bus.wrdata[k % 8];
            end
            if (phase_set[k]) begin
               phase_q[k] <= 1'b1;
            end else if (int'(next_index) == k) begin
               phase_q[k] <= 1'b0;
            end
         end
         if (bus.wrreq && sel.kind == REG_MODE) begin
            atomic_q <= bus.wrdata[MODE_ATOMIC];
            freset_q <= bus.wrdata[MODE_FRESET];
         end
      end
   end

   always_comb begin
      rd_lo  = '0;
      rd_hi  = '0;
      rd_vol = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (int'(sel.chan) == k) begin
            rd_lo  = freq_q[k][7:0];
            rd_hi  = 8'(freq_q[k][FREQ_W-1:8]);
            rd_vol = 8'(vol_q[k]);
         end
      end
      en_ext   = 16'(enable_q);
      rd_value = UNMAPPED_RDATA;
      case (sel.kind)
         REG_FREQ_LO: rd_value = rd_lo;
         REG_FREQ_HI: rd_value = rd_hi;
         REG_VOL:     rd_value = rd_vol;
         REG_EN_LO:   rd_value = en_ext[7:0];
         REG_EN_HI:   rd_value = en_ext[15:8];
         REG_MODE:    rd_value = {2'b00, freset_q, 4'b0000, atomic_q};
         default:     rd_value = UNMAPPED_RDATA;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.rddata    <= 8'h00;
         bus.rddata_en <= 1'b0;
      end else begin
         bus.rddata_en <= rd_accept;
         if (rd_accept) bus.rddata <= rd_value;
      end
   end

   // Slot fields are taken from the channel the sequencer moves to, keeping them aligned with ch_index.
   always_comb begin
      slot_freq  = '0;
      slot_vol   = '0;
      slot_en    = 1'b0;
      slot_phase = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (int'(next_index) == k) begin
            slot_freq  = freq_q[k];
            slot_vol   = vol_q[k];
            slot_en    = enable_q[k];
            slot_phase = phase_q[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_frequency   <= '0;
         ch_volume      <= '0;
         ch_enable      <= 1'b0;
         ch_phase_reset <= 1'b0;
      end else begin
         ch_frequency   <= slot_freq;
         ch_volume      <= slot_vol;
         ch_enable      <= slot_en;
         ch_phase_reset <= slot_phase;
      end
   end

endmodule

// File: tb/tb_scc_channel_regfile.sv
// Self-checking bench for scc_channel_regfile with three channels; read data
// expectations go through a queue and are popped when rddata_en answers.
module tb_scc_channel_regfile;

   logic        clk;
   logic        reset;
   logic        seq_en;
   logic [1:0]  ch_index;
   logic [11:0] ch_frequency;
   logic [3:0]  ch_volume;
   logic        ch_enable;
   logic        ch_phase_reset;
   logic        frame_start;

   int          checks;
   int          errors;
   logic [7:0]  exp_q[$];

   scc_channel_regfile_if bus ();

   scc_channel_regfile #(
      .CHANNELS (3),
      .FREQ_W   (12),
      .VOL_W    (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus.slave),
      .seq_en         (seq_en),
      .ch_index       (ch_index),
      .ch_frequency   (ch_frequency),
      .ch_volume      (ch_volume),
      .ch_enable      (ch_enable),
      .ch_phase_reset (ch_phase_reset),
      .frame_start    (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [5:0] addr, input logic [7:0] data);
      bus.address = addr;
      bus.wrdata  = data;
      bus.wrreq   = 1'b1;
      @(negedge clk);
      bus.wrreq   = 1'b0;
   endtask

   task automatic issue_read(input logic [5:0] addr, input logic [7:0] expected,
                             output logic [7:0] got, output logic got_en, output logic [7:0] want);
      exp_q.push_back(expected);
      bus.address = addr;
      bus.rdreq   = 1'b1;
      @(negedge clk);
      bus.rdreq   = 1'b0;
      got    = bus.rddata;
      got_en = bus.rddata_en;
      want   = exp_q.pop_front();
   endtask

   task automatic wait_index(input logic [1:0] idx, input bit skip, output bit ok);
      ok = 1'b0;
      if (skip) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (ch_index == idx) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [5:0] a_tab[3] = '{6'h3F, 6'h00, 6'h20};
      logic [7:0] got, want;
      logic       en;
      reset = 1'b1;
      seq_en = 1'b0;
      bus.wrreq = 1'b0;
      bus.rdreq = 1'b0;
      bus.address = '0;
      bus.wrdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (ch_index !== 2'd0 || frame_start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_seq: ch_index=%0d frame_start=%b expected 0/1", ch_index, frame_start);
      end
      checks++;
      if (ch_frequency !== 12'h000 || ch_volume !== 4'h0 || ch_enable !== 1'b0 || ch_phase_reset !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ch: freq=%h vol=%h en=%b pr=%b expected all zero",
                  ch_frequency, ch_volume, ch_enable, ch_phase_reset);
      end
      checks++;
      if (bus.rddata !== 8'h00 || bus.rddata_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_rd: rddata=%h en=%b expected 00/0", bus.rddata, bus.rddata_en);
      end
      for (int i = 0; i < 3; i++) begin
         issue_read(a_tab[i], 8'h00, got, en, want);
         checks++;
         if (en !== 1'b1 || got !== want) begin
            errors++;
            $display("[TB] FAIL reset_read_%h: rddata=%h en=%b expected %h en=1", a_tab[i], got, en, want);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.rddata_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rddata_en_pulse: en=%b expected 0", bus.rddata_en);
      end
      checks++;
      if (ch_index !== 2'd0 || frame_start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_hold: ch_index=%0d frame_start=%b expected 0/1", ch_index, frame_start);
      end
      seq_en = 1'b1;
   endtask

   task automatic test_direct_freq();
      logic [5:0] a_tab[2] = '{6'h03, 6'h02};
      logic [7:0] d_tab[2] = '{8'h05, 8'h34};
      logic [7:0] got, want;
      logic       en;
      bit         ok;
      do_write(6'h02, 8'h34);
      do_write(6'h03, 8'hA5);
      for (int i = 0; i < 2; i++) begin
         issue_read(a_tab[i], d_tab[i], got, en, want);
         checks++;
         if (en !== 1'b1 || got !== want) begin
            errors++;
            $display("[TB] FAIL direct_read_%h: rddata=%h en=%b expected %h en=1", a_tab[i], got, en, want);
         end
      end
      wait_index(2'd1, 1'b1, ok);
      checks++;
      if (!ok || ch_frequency !== 12'h534) begin
         errors++;
         $display("[TB] FAIL direct_slot1: ok=%b freq=%h expected 534", ok, ch_frequency);
      end
   endtask

   task automatic test_atomic();
      logic [5:0] a_tab[3] = '{6'h04, 6'h05, 6'h3F};
      logic [7:0] d_tab[3] = '{8'h78, 8'h0C, 8'h01};
      logic [7:0] got, want;
      logic       en;
      bit         ok;
      do_write(6'h3F, 8'h01);
      do_write(6'h04, 8'h78);
      wait_index(2'd2, 1'b1, ok);
      checks++;
      if (!ok || ch_frequency !== 12'h000) begin
         errors++;
         $display("[TB] FAIL atomic_shadow_hidden: ok=%b freq=%h expected 000", ok, ch_frequency);
      end
      do_write(6'h05, 8'h0C);
      wait_index(2'd2, 1'b1, ok);
      checks++;
      if (!ok || ch_frequency !== 12'hC78) begin
         errors++;
         $display("[TB] FAIL atomic_commit: ok=%b freq=%h expected C78", ok, ch_frequency);
      end
      for (int i = 0; i < 3; i++) begin
         issue_read(a_tab[i], d_tab[i], got, en, want);
         checks++;
         if (en !== 1'b1 || got !== want) begin
            errors++;
            $display("[TB] FAIL atomic_read_%h: rddata=%h en=%b expected %h en=1", a_tab[i], got, en, want);
         end
      end
   endtask

   task automatic test_phase_reset();
      bit   ok;
      logic exp_pr;
      do_write(6'h3F, 8'h20);
      // Write issued while channel 0 is on show: pulse lands on the next channel-0 slot (3 cycles later).
      wait_index(2'd0, 1'b0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL phase_wait0: timeout waiting for ch_index 0");
      end
      bus.address = 6'h00;
      bus.wrdata  = 8'h10;
      bus.wrreq   = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         bus.wrreq = 1'b0;
         exp_pr = (n == 3);
         checks++;
         if (ch_phase_reset !== exp_pr) begin
            errors++;
            $display("[TB] FAIL phase_early_n%0d: ch_phase_reset=%b expected %b", n, ch_phase_reset, exp_pr);
         end
      end
      // Write landing on the edge that loads the channel-0 slot: that slot misses it, the next one shows it.
      wait_index(2'd2, 1'b0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL phase_wait2: timeout waiting for ch_index 2");
      end
      bus.address = 6'h00;
      bus.wrdata  = 8'h11;
      bus.wrreq   = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         bus.wrreq = 1'b0;
         exp_pr = (n == 4);
         checks++;
         if (ch_phase_reset !== exp_pr) begin
            errors++;
            $display("[TB] FAIL phase_coincide_n%0d: ch_phase_reset=%b expected %b", n, ch_phase_reset, exp_pr);
         end
      end
   endtask

   task automatic test_unmapped();
      logic [5:0] a_tab[6] = '{6'h26, 6'h06, 6'h33, 6'h30, 6'h31, 6'h21};
      logic [7:0] d_tab[6] = '{8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h0A};
      logic [7:0] got, want;
      logic       en;
      bit         ok;
      do_write(6'h26, 8'h0F);
      do_write(6'h30, 8'hFF);
      do_write(6'h21, 8'hFA);
      for (int i = 0; i < 6; i++) begin
         issue_read(a_tab[i], d_tab[i], got, en, want);
         checks++;
         if (en !== 1'b1 || got !== want) begin
            errors++;
            $display("[TB] FAIL map_read_%h: rddata=%h en=%b expected %h en=1", a_tab[i], got, en, want);
         end
      end
      wait_index(2'd1, 1'b1, ok);
      checks++;
      if (!ok || ch_volume !== 4'hA || ch_enable !== 1'b1) begin
         errors++;
         $display("[TB] FAIL slot1_vol_en: ok=%b vol=%h en=%b expected A/1", ok, ch_volume, ch_enable);
      end
   endtask

   task automatic test_sequencer();
      bit         ok;
      logic [1:0] exp_idx;
      wait_index(2'd0, 1'b0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL seq_wait0: timeout waiting for ch_index 0");
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         exp_idx = 2'(i % 3);
         checks++;
         if (ch_index !== exp_idx || frame_start !== (exp_idx == 2'd0)) begin
            errors++;
            $display("[TB] FAIL seq_step%0d: ch_index=%0d frame_start=%b expected %0d/%b",
                     i, ch_index, frame_start, exp_idx, (exp_idx == 2'd0));
         end
      end
      seq_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (ch_index !== 2'd1 || frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_stall%0d: ch_index=%0d frame_start=%b expected 1/0", i, ch_index, frame_start);
         end
      end
      seq_en = 1'b1;
      @(negedge clk);
      checks++;
      if (ch_index !== 2'd2) begin
         errors++;
         $display("[TB] FAIL seq_resume: ch_index=%0d expected 2", ch_index);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got, want;
      logic       en;
      bus.address = 6'h20;
      bus.wrdata  = 8'h09;
      bus.wrreq   = 1'b1;
      bus.rdreq   = 1'b1;
      @(negedge clk);
      bus.wrreq = 1'b0;
      bus.rdreq = 1'b0;
      checks++;
      if (bus.rddata_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_rd_collision: rddata_en=%b expected 0", bus.rddata_en);
      end
      issue_read(6'h20, 8'h09, got, en, want);
      checks++;
      if (en !== 1'b1 || got !== want) begin
         errors++;
         $display("[TB] FAIL collision_readback: rddata=%h en=%b expected %h en=1", got, en, want);
      end
   endtask

   task automatic test_reset_midop();
      logic [5:0] a_tab[4] = '{6'h3F, 6'h00, 6'h02, 6'h03};
      logic [7:0] d_tab[4] = '{8'h00, 8'h00, 8'h00, 8'h0A};
      logic [7:0] got, want;
      logic       en;
      do_write(6'h3F, 8'h21);
      do_write(6'h00, 8'h55);
      do_write(6'h01, 8'h03);
      do_write(6'h02, 8'h66);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ch_index !== 2'd0 || frame_start !== 1'b1 || ch_frequency !== 12'h000 || bus.rddata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL async_reset: idx=%0d fs=%b freq=%h rddata=%h expected 0/1/000/00",
                  ch_index, frame_start, ch_frequency, bus.rddata);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ch_phase_reset !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_discard_phase%0d: ch_phase_reset=%b expected 0", i, ch_phase_reset);
         end
      end
      do_write(6'h03, 8'h0A);
      for (int i = 0; i < 4; i++) begin
         issue_read(a_tab[i], d_tab[i], got, en, want);
         checks++;
         if (en !== 1'b1 || got !== want) begin
            errors++;
            $display("[TB] FAIL post_reset_read_%h: rddata=%h en=%b expected %h en=1", a_tab[i], got, en, want);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_direct_freq();
      test_atomic();
      test_phase_reset();
      test_unmapped();
      test_sequencer();
      test_back_to_back();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/scc_channel_regfile.md
# scc_channel_regfile

Parametrised successor to the fixed five-channel SCC control-register set. It holds frequency, volume, enable and mode registers for `CHANNELS` wave channels, with byte-wide CPU write/read access. It adds atomic frequency commit and per-channel phase-reset requests. An internal channel sequencer presents one channel's parameters per cycle to the time-multiplexed wave engine, so no external `active` selector is needed.

## Interface
- `CHANNELS`, default 5: number of channels, 1..16.
- `FREQ_W`, default 12: frequency counter width, 9..16.
- `VOL_W`, default 4: volume width, 1..8.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `wrreq`  in  1: one-cycle write strobe.
- `rdreq`  in  1: one-cycle read strobe.
- `address`  in  6: register offset inside the decoded SCC window.
- `wrdata`  in  8: write data.
- `rddata`  out  8: read data, held between reads.
- `rddata_en`  out  1: one-cycle pulse when `rddata` is updated.
- `seq_en`  in  1: advance the sequencer this cycle.
- `ch_index`  out  $clog2(CHANNELS) (min 1): channel shown on `ch_*`.
- `ch_frequency`  out  FREQ_W: committed frequency of `ch_index`.
- `ch_volume`  out  VOL_W: volume of `ch_index`.
- `ch_enable`  out  1: enable of `ch_index`.
- `ch_phase_reset`  out  1: phase-reset request for `ch_index`.
- `frame_start`  out  1: high while `ch_index`==0.

## Operation
- Address map:
  - 0x00+2k: freq[7:0] of channel k.
  - 0x01+2k: freq[FREQ_W-1:8] of channel k; upper `wrdata` bits are ignored.
  - 0x20+k: volume of channel k, `wrdata[VOL_W-1:0]`.
  - 0x30: enable bits for channels 0..7.
  - 0x31: enable bits for channels 8..15.
  - 0x3F: mode register. Bit0 = `atomic`, bit5 = `freq_reset`.
  - Addresses for k ≥ CHANNELS, and unmapped addresses: writes are ignored, reads return 0xFF.
- `atomic`=0:
  - Low-byte write updates the committed value immediately.
  - High-byte write updates the committed value immediately.
- `atomic`=1:
  - Low-byte write goes to the channel's shadow byte and sets its pending flag.
  - High-byte write commits {wrdata, shadow if pending else committed low} and clears pending.
- Any change to a channel's committed frequency (either mode) while `freq_reset`=1 sets that channel's phase-reset flag.
- Phase-reset flag handling:
  - `ch_phase_reset` = flag of `ch_index`; the flag clears when that slot is output.
  - If a set and that channel's slot coincide, the set wins: the flag stays pending and is output on the next visit.
- Reads:
  - Freq reads return the committed value, zero-padded; the shadow is never readable.
  - Enable reads return 0 for absent channels.
  - Mode read returns {2'b0, freq_reset, 4'b0, atomic}.
- `wrreq` and `rdreq` in the same cycle: the write is performed, the read is dropped (no `rddata_en`).
- Sequencer: `ch_index` increments when `seq_en`=1 and wraps from CHANNELS-1 to 0. It holds when `seq_en`=0.

## Timing
- All outputs are registered.
- Reset values:
  - All registers, shadows, pending and phase-reset flags = 0.
  - `ch_index`=0, `ch_*`=0.
  - `frame_start`=1.
  - `rddata`=0x00, `rddata_en`=0.
- Write at cycle T: register updated at the T+1 edge. `ch_*` reflect it at the first slot of that channel starting at or after T+2.
- Read at cycle T: `rddata` valid and `rddata_en`=1 in cycle T+1.
- `ch_*` are aligned with `ch_index` in the same cycle; no extra skew between fields.
- Reset asserted mid-operation: state clears immediately (asynchronous). Pending shadows and phase-reset flags are discarded, and the sequencer restarts at 0.

## Structure
- `scc_regfile_pkg` holds:
  - Address constants: `FREQ_BASE`=0x00, `VOL_BASE`=0x20, `EN_BASE`=0x30, `MODE_ADDR`=0x3F.
  - Mode bit indices: `MODE_ATOMIC`=0, `MODE_FRESET`=5.
  - The unmapped read value 0xFF.
- Sub-module `scc_channel_sequencer`: wrap counter with `seq_en` that generates `ch_index` and `frame_start`. The register file and output muxing stay in the top.

## Test plan
- Reset, then read 0x3F, 0x00 and 0x20: `rddata` 0x00 each, `rddata_en` one cycle after each `rdreq`; `ch_index` 0, `frame_start` 1.
- `atomic`=0: write 0x02←0x34, then 0x03←0xA5, then read 0x03: 0x05. Channel 1 slot shows `ch_frequency` 0x534.
- Set mode 0x01. Write 0x04←0x78 and check the channel-2 slot still shows 0x000. Write 0x05←0x0C: the slot shows 0xC78 and read 0x04 returns 0x78.
- Set mode 0x20 and write 0x00←0x10: `ch_phase_reset` high only in the next channel-0 slot. Repeat with the write timed to land on the channel-0 slot: the pulse comes one full rotation later.
- CHANNELS=3:
  - Write 0x26←0x0F: ignored.
  - Read 0x26: 0xFF.
  - Write 0x30←0xFF, then read 0x30: 0x07.
  - `ch_index` sequence 0,1,2,0 with `seq_en` held high; it stalls when `seq_en`=0.
- Simultaneous `wrreq`+`rdreq` to 0x20 with `wrdata`=0x09: no `rddata_en`; the next read returns 0x09.
